// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared sizes, FSM states and alignment rule for the load/store unit
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  // Size 2'b11 has no legal encoding, so it is reported as misaligned.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: lsu_misaligned = 1'b0;
      LSU_SIZE_H: lsu_misaligned = off[0];
      LSU_SIZE_W: lsu_misaligned = (off != 2'b00);
      default:    lsu_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte strobes, store lane replication and load extract/extend
// Ports:
//   size, uns, off    access size, zero-extend flag, address bits [1:0]
//   wdata             raw store data
//   rdata             raw memory read word
//   wstrb             byte strobes for the access
//   wdata_lanes       store data replicated into every lane
//   rdata_ext         selected lane, sign- or zero-extended to 32 bits
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane   = rdata[{off, 3'b000} +: 8];
    half_lane   = off[1] ? rdata[31:16] : rdata[15:0];
    wstrb       = 4'b0000;
    wdata_lanes = wdata;
    rdata_ext   = rdata;
    case (size)
      LSU_SIZE_B: begin
        wstrb       = 4'b0001 << off;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{~uns & byte_lane[7]}}, byte_lane};
      end
      LSU_SIZE_H: begin
        wstrb       = 4'b0011 << {off[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{~uns & half_lane[15]}}, half_lane};
      end
      LSU_SIZE_W: begin
        wstrb = 4'b1111;
      end
      default: begin
        wstrb = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: one req/gnt/rvalid memory transaction per request
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   valid_i/ready_o               request handshake from execute
//   is_store_i, size_i,
//   unsigned_i, addr_i, wdata_i   access description
//   done_o, rdata_o, misaligned_o registered completion results
//   mem_req_o .. mem_wdata_o      registered memory request
//   mem_gnt_i, mem_rvalid_i,
//   mem_rdata_i                   memory grant and read response
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic            is_store_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            ready_o,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            misaligned_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [3:0]      mem_wstrb_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  lsu_state_e  state;
  logic        is_store_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;

  logic [1:0]  al_size;
  logic        al_uns;
  logic [1:0]  al_off;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;
  logic        accept;

  assign ready_o = (state == LSU_IDLE);
  assign accept  = valid_i & ready_o;

  // In IDLE the aligner sees the incoming request (strobes/lanes); afterwards
  // it sees the latched access so the load response is extracted correctly.
  assign al_size = ready_o ? size_i        : size_q;
  assign al_uns  = ready_o ? unsigned_i    : uns_q;
  assign al_off  = ready_o ? addr_i[1:0]   : off_q;

  lsu_align u_align (
    .size        (al_size),
    .uns         (al_uns),
    .off         (al_off),
    .wdata       (wdata_i),
    .rdata       (mem_rdata_i),
    .wstrb       (al_wstrb),
    .wdata_lanes (al_wdata),
    .rdata_ext   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LSU_IDLE;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      done_o       <= 1'b0;
      rdata_o      <= '0;
      misaligned_o <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wstrb_o  <= 4'b0000;
      mem_wdata_o  <= '0;
    end else begin
      done_o       <= 1'b0;
      misaligned_o <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            is_store_q <= is_store_i;
            size_q     <= size_i;
            uns_q      <= unsigned_i;
            off_q      <= addr_i[1:0];
            if (lsu_misaligned(size_i, addr_i[1:0])) begin
              done_o       <= 1'b1;
              misaligned_o <= 1'b1;
            end else begin
              state       <= LSU_REQ;
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store_i;
              mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
              mem_wstrb_o <= al_wstrb;
              mem_wdata_o <= al_wdata;
            end
          end
        end
        LSU_REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            if (is_store_q) begin
              done_o <= 1'b1;
              state  <= LSU_IDLE;
            end else begin
              state  <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (mem_rvalid_i) begin
            rdata_o <= al_rdata;
            done_o  <= 1'b1;
            state   <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu with a behavioural reference model
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        is_store_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        misaligned_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] last_rdata;

  always #5 clk = ~clk;

  lsu dut (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .is_store_i   (is_store_i),
    .size_i       (size_i),
    .unsigned_i   (unsigned_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ready_o      (ready_o),
    .done_o       (done_o),
    .rdata_o      (rdata_o),
    .misaligned_o (misaligned_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wstrb_o  (mem_wstrb_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request from accept to completion and checks every cycle.
  // gdly: REQ cycles without grant; rdly: WAIT cycles without rvalid;
  // noise: pulse rvalid with junk data while in REQ.
  task automatic do_txn(input string nm, input logic st, input logic [1:0] sz,
                        input logic un, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gdly, input int rdly,
                        input logic noise);
    int nb;
    logic e_mis;
    logic [3:0] e_strb;
    logic [31:0] e_wd, e_rd, e_addr, v;

    nb     = (sz == 2'd3) ? 1 : (1 << sz);
    e_mis  = (sz == 2'd3) || ((a % nb) != 0);
    e_strb = 4'(((1 << nb) - 1) << (a % 4));
    e_addr = a - (a % 4);
    if (nb == 1)      e_wd = {24'd0, wd[7:0]} * 32'h01010101;
    else if (nb == 2) e_wd = {16'd0, wd[15:0]} * 32'h00010001;
    else              e_wd = wd;
    if (nb == 1) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (!un && v >= 128) v = v + 32'hFFFFFF00;
    end else if (nb == 2) begin
      v = (rd >> (8 * (a % 4))) & 32'hFFFF;
      if (!un && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    e_rd = v;

    valid_i = 1'b1; is_store_i = st; size_i = sz; unsigned_i = un;
    addr_i = a; wdata_i = wd;
    step();
    valid_i = 1'b0; addr_i = $urandom; wdata_i = $urandom; size_i = 2'($urandom);

    if (e_mis) begin
      total_cnt++; if (done_o !== 1'b1) $display("FAIL %s mis_done got %b want 1", nm, done_o); else pass_cnt++;
      total_cnt++; if (misaligned_o !== 1'b1) $display("FAIL %s misaligned got %b want 1", nm, misaligned_o); else pass_cnt++;
      total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL %s mis_req got %b want 0", nm, mem_req_o); else pass_cnt++;
      total_cnt++; if (rdata_o !== last_rdata) $display("FAIL %s mis_rdata_hold got %h want %h", nm, rdata_o, last_rdata); else pass_cnt++;
      return;
    end

    for (int i = 0; i <= gdly; i++) begin
      total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL %s req[%0d] got %b want 1", nm, i, mem_req_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b0) $display("FAIL %s ready_in_req[%0d] got %b want 0", nm, i, ready_o); else pass_cnt++;
      total_cnt++; if (done_o !== 1'b0) $display("FAIL %s done_in_req[%0d] got %b want 0", nm, i, done_o); else pass_cnt++;
      total_cnt++; if (mem_we_o !== st) $display("FAIL %s we[%0d] got %b want %b", nm, i, mem_we_o, st); else pass_cnt++;
      total_cnt++; if (mem_addr_o !== e_addr) $display("FAIL %s addr[%0d] got %h want %h", nm, i, mem_addr_o, e_addr); else pass_cnt++;
      if (st) begin
        total_cnt++; if (mem_wstrb_o !== e_strb) $display("FAIL %s wstrb[%0d] got %b want %b", nm, i, mem_wstrb_o, e_strb); else pass_cnt++;
        total_cnt++; if (mem_wdata_o !== e_wd) $display("FAIL %s wdata[%0d] got %h want %h", nm, i, mem_wdata_o, e_wd); else pass_cnt++;
      end
      if (i < gdly) begin
        mem_rvalid_i = noise; mem_rdata_i = $urandom;
        step();
        mem_rvalid_i = 1'b0;
      end
    end

    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL %s req_after_gnt got %b want 0", nm, mem_req_o); else pass_cnt++;

    if (st) begin
      total_cnt++; if (done_o !== 1'b1) $display("FAIL %s st_done got %b want 1", nm, done_o); else pass_cnt++;
      total_cnt++; if (misaligned_o !== 1'b0) $display("FAIL %s st_mis got %b want 0", nm, misaligned_o); else pass_cnt++;
      total_cnt++; if (ready_o !== 1'b1) $display("FAIL %s st_ready got %b want 1", nm, ready_o); else pass_cnt++;
      total_cnt++; if (rdata_o !== last_rdata) $display("FAIL %s st_rdata_hold got %h want %h", nm, rdata_o, last_rdata); else pass_cnt++;
      return;
    end

    for (int i = 0; i < rdly; i++) begin
      total_cnt++; if (done_o !== 1'b0 || ready_o !== 1'b0) $display("FAIL %s wait[%0d] done/ready got %b%b want 00", nm, i, done_o, ready_o); else pass_cnt++;
      step();
    end
    total_cnt++; if (done_o !== 1'b0) $display("FAIL %s done_in_wait got %b want 0", nm, done_o); else pass_cnt++;
    mem_rvalid_i = 1'b1; mem_rdata_i = rd;
    step();
    mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
    total_cnt++; if (done_o !== 1'b1) $display("FAIL %s ld_done got %b want 1", nm, done_o); else pass_cnt++;
    total_cnt++; if (misaligned_o !== 1'b0) $display("FAIL %s ld_mis got %b want 0", nm, misaligned_o); else pass_cnt++;
    total_cnt++; if (rdata_o !== e_rd) $display("FAIL %s ld_rdata got %h want %h", nm, rdata_o, e_rd); else pass_cnt++;
    last_rdata = e_rd;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b0; is_store_i = 1'b0; size_i = 2'b00; unsigned_i = 1'b0;
    addr_i = '0; wdata_i = '0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    step(); step();
    rst = 1'b0;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL reset ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL reset done got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL reset req got %b want 0", mem_req_o); else pass_cnt++;
    total_cnt++; if (misaligned_o !== 1'b0) $display("FAIL reset mis got %b want 0", misaligned_o); else pass_cnt++;
    total_cnt++; if (rdata_o !== 32'h0) $display("FAIL reset rdata got %h want 0", rdata_o); else pass_cnt++;
    total_cnt++; if ({mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o} !== 69'h0) $display("FAIL reset mem_outs nonzero we=%b addr=%h strb=%b wd=%h", mem_we_o, mem_addr_o, mem_wstrb_o, mem_wdata_o); else pass_cnt++;
    last_rdata = 32'h0;
  endtask

  task automatic test_directed();
    do_txn("st_byte",  1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0, 1'b0);
    step();
    do_txn("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
    step();
    do_txn("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, 0, 1'b0);
    step();
    do_txn("ld_word_mis", 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'h0, 0, 0, 1'b0);
    step();
    do_txn("size11_mis", 1'b0, 2'b11, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 0, 1'b0);
    step();
    do_txn("ld_byte_s", 1'b0, 2'b00, 1'b0, 32'h0000_4001, 32'h0, 32'h1234_F600, 0, 1, 1'b0);
    step();
  endtask

  task automatic test_grant_stall();
    do_txn("st_word_stall", 1'b1, 2'b10, 1'b0, 32'h0000_5008, 32'hDEAD_BEEF, 32'h0, 3, 0, 1'b0);
    step();
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_ld",  1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
    do_txn("b2b_st",  1'b1, 2'b01, 1'b0, 32'h0000_6006, 32'h0000_5A5A, 32'h0, 2, 0, 1'b1);
    do_txn("b2b_ld2", 1'b0, 2'b00, 1'b1, 32'h0000_6003, 32'h0, 32'h9100_0000, 2, 0, 1'b1);
    do_txn("b2b_mis", 1'b1, 2'b01, 1'b0, 32'h0000_6001, 32'h1, 32'h0, 0, 0, 1'b0);
    step();
  endtask

  task automatic test_random();
    logic [1:0] sz;
    logic [31:0] a;
    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      do_txn($sformatf("rnd%0d", n), 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
      if ($urandom_range(0, 1) != 0) step();
    end
  endtask

  task automatic test_reset_in_wait();
    valid_i = 1'b1; is_store_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h0000_7000;
    step();
    valid_i = 1'b0;
    total_cnt++; if (mem_req_o !== 1'b1) $display("FAIL rst_wait req got %b want 1", mem_req_o); else pass_cnt++;
    mem_gnt_i = 1'b1;
    step();
    mem_gnt_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (ready_o !== 1'b1) $display("FAIL rst_wait ready got %b want 1", ready_o); else pass_cnt++;
    total_cnt++; if (mem_req_o !== 1'b0) $display("FAIL rst_wait req_after got %b want 0", mem_req_o); else pass_cnt++;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL rst_wait done got %b want 0", done_o); else pass_cnt++;
    last_rdata = 32'h0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1357_9BDF;
    step();
    mem_rvalid_i = 1'b0;
    total_cnt++; if (done_o !== 1'b0) $display("FAIL late_rvalid done got %b want 0", done_o); else pass_cnt++;
    total_cnt++; if (rdata_o !== last_rdata) $display("FAIL late_rvalid rdata got %h want %h", rdata_o, last_rdata); else pass_cnt++;
    step();
    total_cnt++; if (done_o !== 1'b0) $display("FAIL late_rvalid done2 got %b want 0", done_o); else pass_cnt++;
    do_txn("after_rst", 1'b0, 2'b00, 1'b0, 32'h0000_7002, 32'h0, 32'h0080_0000, 0, 0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_grant_stall();
    test_back_to_back();
    test_random();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
